// File: rtl/serial_add_ctrl_pkg.sv
// Shared state encodings, default width and full-adder helper for the bit-serial adder.
// Both the controller and its 1-bit slice import this package.
package serial_add_ctrl_pkg;

  localparam int unsigned SaDefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sa_state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational 1-bit full adder, shared across all bit positions by the serial controller.
module fa_slice
  import serial_add_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj3(a, b, ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped over WIDTH cycles per operation.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SaDefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  sa_state_e        state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Bit 0 of the sum shift register is never needed: the final bit is taken from the slice.
  logic [WIDTH-1:1] ss_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] ss_next;
  logic             last_bit;

  fa_slice u_fa_slice (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (c_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign ss_next  = {slice_s, ss_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            ss_q    <= '0;
            c_q     <= cin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          c_q   <= slice_co;
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          ss_q  <= ss_next[WIDTH-1:1];
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            sum     <= ss_next;
            cout    <= slice_co;
`ifdef SERIAL_ADD_OVF_EN
            // c_q is the carry into the MSB slice on this cycle.
            ovf     <= c_q ^ slice_co;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=4): directed cases, abort on reset, full sweep.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vectors are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int n_checks;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [W+1:0] observed();
`ifdef SERIAL_ADD_OVF_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  function automatic logic [W+1:0] masked(input logic [W+1:0] e);
    logic [W+1:0] r;
    r = e;
`ifndef SERIAL_ADD_OVF_EN
    r[W+1] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
    return {ov, r};
  endfunction

  // Monitor: pops on every done pulse, otherwise the outputs must hold the last result.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (reset) begin
      exp_q.delete();
      last_exp = '0;
    end else if (done) begin
      check("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'(observed()), 32'(masked(e)));
        last_exp = e;
      end
    end else begin
      check("hold", 32'(observed()), 32'(masked(last_exp)));
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W+1:0] expv);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc, input int exp_busy);
    int cyc;
    int bc;
    cyc = 0;
    bc  = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy) bc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({nm, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({nm, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic count_quiet(input string nm, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check({nm, "_no_done"}, 32'(nd), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] v;
    n_checks = 0;
    n_fail   = 0;
    last_exp = '0;
    reset    = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases: {ovf, cout, sum}.
    launch(4'b0111, 4'b0001, 1'b0, {1'b1, 1'b0, 4'b1000});
    wait_done("t1", W + 1, W);
    launch(4'b1111, 4'b0001, 1'b0, {1'b0, 1'b1, 4'b0000});
    wait_done("t2", W + 1, W);
    launch(4'b0000, 4'b0000, 1'b1, {1'b0, 1'b0, 4'b0001});
    wait_done("t3a", W + 1, W);
    launch(4'b1111, 4'b1111, 1'b1, {1'b0, 1'b1, 4'b1111});
    wait_done("t3b", W + 1, W);

    // start re-pulsed mid-RUN with new operands must be ignored.
    launch(4'b0011, 4'b0100, 1'b1, {1'b1, 1'b0, 4'b1000});
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'b0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t4", W - 1, W - 2);
    count_quiet("t4", 10);

    // Reset in the middle of an operation aborts it.
    launch(4'b0001, 4'b0010, 1'b0, {1'b0, 1'b0, 4'b0011});
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    count_quiet("t5", 10);
    launch(4'b0101, 4'b0011, 1'b0, {1'b1, 1'b0, 4'b1000});
    wait_done("t5_after", W + 1, W);

    // Exhaustive sweep with start held high: one acceptance every W+2 cycles.
    start = 1'b1;
    for (int i = 0; i < 512; i++) begin
      v   = 9'(i);
      a   = v[8:5];
      b   = v[4:1];
      cin = v[0];
      exp_q.push_back(model(v[8:5], v[4:1], v[0]));
      repeat (W + 2) @(posedge clk);
      #1;
    end
    start = 1'b0;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check("sweep_drain", 32'(exp_q.size()), 32'd0);
    count_quiet("end", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
